// File: rtl/serial_adder_if.sv
// Operand/result bundle for the serial adder.
// The master side issues start with operands; the slave side returns registered results, busy and done.
interface serial_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, sub, a, b, cin,
        input  sum, cout, overflow, zero, busy, done
    );

    modport slave (
        input  start, sub, a, b, cin,
        output sum, cout, overflow, zero, busy, done
    );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor that processes CHUNK bits per clock, LSB chunk first.
// Results are assembled internally and published to sum/cout/overflow/zero on the final chunk edge.
module serial_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus,
    output logic [1:0]    dbg_state
);
    // Handshake: start is accepted on any rising edge where busy=0 (IDLE or DONE);
    // done is high for exactly one cycle, the cycle in which the new results first appear.
    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             carry;
    logic [KW-1:0]    k;
    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic [CHUNK:0]   csum;
    logic             last;
    logic             accept;
    logic             msb_cin;
    int               base;

    // Chunk datapath: one CHUNK-wide add of the selected slice plus the running carry.
    always_comb begin
        base    = int'(k) * CHUNK;
        ca      = op_a[base +: CHUNK];
        cb      = op_b[base +: CHUNK];
        csum    = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry};
        acc_nxt = acc;
        acc_nxt[base +: CHUNK] = csum[CHUNK-1:0];
        last    = (k == KW'(NCH - 1));
        accept  = bus.start && (state != RUN);
        // Carry into the top bit recovered from its sum bit: s = a ^ b ^ c_in.
        msb_cin = op_a[WIDTH-1] ^ op_b[WIDTH-1] ^ csum[CHUNK-1];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a         <= '0;
            op_b         <= '0;
            acc          <= '0;
            carry        <= 1'b0;
            k            <= '0;
            bus.sum      <= '0;
            bus.cout     <= 1'b0;
            bus.overflow <= 1'b0;
            bus.zero     <= 1'b1;
        end else if (accept) begin
            // Subtraction is a + ~b + 1, so the inversion and the forced carry happen at capture.
            op_a  <= bus.a;
            op_b  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub | bus.cin;
            k     <= '0;
        end else if (state == RUN) begin
            acc   <= acc_nxt;
            carry <= csum[CHUNK];
            k     <= k + KW'(1);
            if (last) begin
                bus.sum      <= acc_nxt;
                bus.cout     <= csum[CHUNK];
                bus.overflow <= csum[CHUNK] ^ msb_cin;
                bus.zero     <= (acc_nxt == '0);
            end
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign dbg_state = state;
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning the operand and result width in bits.
REQ-002 The module SHALL have parameter CHUNK, default 8, meaning the bits added per clock; legal only if CHUNK >= 1 and WIDTH % CHUNK == 0; NCH = WIDTH/CHUNK.
REQ-003 The module SHALL have one clock and synchronous active-low reset: clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 start  in  1  request a new operation; sampled only when busy=0.
REQ-006 sub  in  1  0 = add, 1 = subtract; captured with start.
REQ-007 a  in  WIDTH  operand A; captured with start.
REQ-008 b  in  WIDTH  operand B; captured with start.
REQ-009 cin  in  1  carry-in for add; ignored when sub=1; captured with start.
REQ-010 sum  out  WIDTH  result, registered.
REQ-011 cout  out  1  carry out of bit WIDTH-1; for sub, 1 = no borrow.
REQ-012 overflow  out  1  two's-complement signed overflow.
REQ-013 zero  out  1  1 when sum == 0.
REQ-014 busy  out  1  high while an operation is in progress.
REQ-015 done  out  1  single-cycle pulse when results become valid.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 In IDLE or DONE, start=1 at an edge SHALL capture a, ~b if sub=1 else b, and initial carry (1 if sub=1 else cin), clear the chunk index to 0, and enter RUN.
REQ-018 In RUN, each edge SHALL add chunk k of both operands plus the running carry, write sum[k*CHUNK +: CHUNK], update the carry and increment k, LSB chunk first.
REQ-019 On the edge that processes chunk NCH-1, the block SHALL enter DONE and update sum, cout, overflow and zero together.
REQ-020 Latency SHALL be as follows: start sampled at edge 0, done=1 after edge NCH, busy=1 from after edge 0 through after edge NCH-1.
REQ-021 For CHUNK == WIDTH, done SHALL assert after edge 1.
REQ-022 In DONE without start, the next edge SHALL return the FSM to IDLE and drop done.
REQ-023 A start accepted in DONE SHALL give a back-to-back operation, with done=0 and busy=1 after that edge.
REQ-024 start while busy=1 SHALL be ignored, with no effect on operands, progress or outputs.
REQ-025 overflow SHALL equal (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-026 sum, cout, overflow and zero SHALL hold their last values in IDLE, in DONE and across RUN until the final chunk edge.
REQ-027 sum SHALL never expose partial results: chunks SHALL accumulate in an internal register and transfer to sum on the final edge.
REQ-028 sub, a, b and cin SHALL be don't-care except at an accepted start edge.

Reset
REQ-029 rst_n=0 at an edge SHALL force the FSM to IDLE and clear sum, cout, overflow, busy, done, the internal carry and the chunk index to 0, with zero=1.
REQ-030 Reset SHALL override start and any operation in progress; an aborted operation SHALL produce no done pulse.
REQ-031 After rst_n returns high, the first start SHALL be accepted on the next edge.

Verification (WIDTH=32, CHUNK=8, NCH=4)
REQ-032 Reset: hold rst_n=0 for 2 edges -> sum=0, cout=0, overflow=0, busy=0, done=0, zero=1.
REQ-033 Add with cross-chunk carry: a=0x000000FF, b=0x00000001, cin=0 -> done after edge 4, sum=0x00000100, cout=0, overflow=0, zero=0.
REQ-034 Signed overflow: a=0x7FFFFFFF, b=0x00000001 add -> sum=0x80000000, overflow=1, cout=0. Also a=0xFFFFFFFF, b=0, cin=1 -> sum=0, cout=1, zero=1, overflow=0.
REQ-035 Subtract: 5-5 -> sum=0, zero=1, cout=1, overflow=0. 0-1 -> sum=0xFFFFFFFF, cout=0. 0x80000000-1 -> sum=0x7FFFFFFF, overflow=1.
REQ-036 Handshake: start pulsed during RUN -> ignored, result unchanged. start held in the DONE cycle -> second operation completes 4 edges later, with exactly one done pulse per operation.
REQ-037 Reset mid-operation: rst_n=0 after edge 2 of RUN -> IDLE with all outputs at reset values, no done. A new start then completes normally.
